// File: rtl/mul_accumulate.sv
// mul_accumulate: reduces SIZE registered 64-bit partial products, LANES per
// cycle, into a 64-bit product and returns the selected 32-bit half through a
// valid/ready handshake.
// Optional build macro MUL_ACC_ZERO_SKIP_EN: an all-zero request skips the
// accumulate beats and goes straight to DONE with a zero result.
module mul_accumulate #(
  parameter int SIZE  = 16,
  parameter int LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [64*SIZE-1:0]   partial_i,
  input  logic [1:0]           sign_i,
  input  logic                 higher_i,
  input  logic                 clear_i,
  input  logic                 ready_i,
  output logic                 busy_o,
  output logic                 valid_o,
  output logic [31:0]          result_o,
  output logic [1:0]           sign_o
);

  localparam int NBEAT = SIZE / LANES;
  localparam int CW    = $clog2(NBEAT) + 1;
  localparam int IW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam int BW    = 64 * LANES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [64*SIZE-1:0]   buf_reg;
  logic [63:0]          acc_reg;
  logic [CW-1:0]        cnt_reg;
  logic                 hi_reg;
  logic [1:0]           sign_reg;
  logic [31:0]          result_reg;

  logic [BW-1:0]        beat_arr [NBEAT];
  logic [63:0]          lane_val [LANES];
  logic [BW-1:0]        beat_sel;
  logic [63:0]          beat_sum;
  logic [63:0]          acc_next;
  logic                 last_beat;
  logic                 all_zero;

  // Split the buffer into one group of LANES slices per accumulate beat.
  generate
    for (genvar gi = 0; gi < NBEAT; gi++) begin : g_beat
      assign beat_arr[gi] = buf_reg[gi*BW +: BW];
    end
  endgenerate

  assign beat_sel = beat_arr[cnt_reg[IW-1:0]];

  // Individual 64-bit lanes of the beat currently being reduced.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_val[gi] = beat_sel[gi*64 +: 64];
    end
  endgenerate

  // Sum of the current beat's lanes; carries out of bit 63 are dropped.
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      beat_sum = beat_sum + lane_val[i];
    end
  end

  assign acc_next  = acc_reg + beat_sum;
  assign last_beat = (cnt_reg == CW'(NBEAT - 1));

`ifdef MUL_ACC_ZERO_SKIP_EN
  assign all_zero = (partial_i == '0);
`else
  assign all_zero = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; a flush overrides every other transition.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          state_next = all_zero ? DONE : ACC;
        end
      end
      ACC: begin
        if (last_beat) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (ready_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (clear_i) begin
      state_next = IDLE;
    end
  end

  // Capture, accumulate and result registers; nothing moves during a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_reg    <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      hi_reg     <= 1'b0;
      sign_reg   <= 2'b00;
      result_reg <= '0;
    end else if (!clear_i) begin
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            buf_reg  <= partial_i;
            hi_reg   <= higher_i;
            sign_reg <= sign_i;
            acc_reg  <= '0;
            cnt_reg  <= '0;
            if (all_zero) begin
              result_reg <= '0;
            end
          end
        end
        ACC: begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg + CW'(1);
          if (last_beat) begin
            result_reg <= hi_reg ? acc_next[63:32] : acc_next[31:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy_o   = (state_reg != IDLE);
  assign valid_o  = (state_reg == DONE);
  assign result_o = result_reg;
  assign sign_o   = sign_reg;

endmodule

// File: tb/tb_mul_accumulate.sv
// Randomized self-checking bench for mul_accumulate; the reference is a plain
// modulo-2^64 sum of the partial products with half selection.
module tb_mul_accumulate;

  localparam int SIZE  = 16;
  localparam int LANES = 4;
  localparam int NBEAT = SIZE / LANES;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start_i = 1'b0;
  logic [64*SIZE-1:0]  partial_i = '0;
  logic [1:0]          sign_i = 2'b00;
  logic                higher_i = 1'b0;
  logic                clear_i = 1'b0;
  logic                ready_i = 1'b0;
  logic                busy_o;
  logic                valid_o;
  logic [31:0]         result_o;
  logic [1:0]          sign_o;

  int total = 0;
  int bad   = 0;
  logic [63:0] sl [SIZE];

  mul_accumulate #(.SIZE(SIZE), .LANES(LANES)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .partial_i (partial_i),
    .sign_i    (sign_i),
    .higher_i  (higher_i),
    .clear_i   (clear_i),
    .ready_i   (ready_i),
    .busy_o    (busy_o),
    .valid_o   (valid_o),
    .result_o  (result_o),
    .sign_o    (sign_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_product();
    logic [63:0] s;
    s = '0;
    for (int k = 0; k < SIZE; k++) s = s + sl[k];
    return s;
  endfunction

  function automatic int model_latency();
`ifdef MUL_ACC_ZERO_SKIP_EN
    bit z;
    z = 1'b1;
    for (int k = 0; k < SIZE; k++) if (sl[k] != 64'd0) z = 1'b0;
    if (z) return 1;
`endif
    return NBEAT + 1;
  endfunction

  task automatic load_partials();
    for (int k = 0; k < SIZE; k++) partial_i[k*64 +: 64] = sl[k];
  endtask

  task automatic clear_slices();
    for (int k = 0; k < SIZE; k++) sl[k] = '0;
  endtask

  task automatic random_slices();
    int mode;
    for (int k = 0; k < SIZE; k++) begin
      mode = $urandom_range(0, 2);
      if (mode == 0)      sl[k] = 64'($urandom_range(0, 1000));
      else if (mode == 1) sl[k] = {$urandom, $urandom};
      else                sl[k] = 64'd0 - 64'($urandom_range(1, 100000));
    end
  endtask

  // One request: start, wait for valid, check result, apply backpressure, retire.
  task automatic run_txn(input string tag, input logic hi, input logic [1:0] sg,
                         input int hold, input bit poke);
    logic [63:0] p;
    logic [31:0] exp_res;
    int n;
    p = model_product();
    exp_res = hi ? p[63:32] : p[31:0];
    load_partials();
    higher_i = hi;
    sign_i   = sg;
    ready_i  = (hold == 0);
    start_i  = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    n = 1;
    if (poke) partial_i = {SIZE{$urandom, $urandom}};
    while (!valid_o && n < 40) begin
      start_i = (poke && n == 2);
      @(posedge clk); #1;
      n++;
    end
    start_i = 1'b0;
    check({tag, "_lat"}, 64'(n), 64'(model_latency()));
    check({tag, "_res"}, 64'(result_o), 64'(exp_res));
    check({tag, "_sign"}, 64'(sign_o), 64'(sg));
    check({tag, "_busy"}, 64'(busy_o), 64'd1);
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 64'(valid_o), 64'd1);
      check({tag, "_hold_res"}, 64'(result_o), 64'(exp_res));
    end
    ready_i = 1'b1;
    @(posedge clk); #1;
    check({tag, "_retire_valid"}, 64'(valid_o), 64'd0);
    check({tag, "_retire_busy"}, 64'(busy_o), 64'd0);
    if (poke) begin
      for (int c = 0; c < NBEAT + 2; c++) begin
        @(posedge clk); #1;
        check({tag, "_no_extra"}, 64'(valid_o), 64'd0);
      end
    end
    $display("txn %s hi=%0d product=%h result=%h lat=%0d", tag, hi, p, result_o, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] p;
    #1 rst = 1'b1;
    #1;
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_valid", 64'(valid_o), 64'd0);
    check("reset_result", 64'(result_o), 64'd0);
    check("reset_sign", 64'(sign_o), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Small sum
    clear_slices(); sl[0] = 64'd5; sl[1] = 64'd7;
    run_txn("small", 1'b0, 2'b00, 0, 1'b0);
    // High half carry
    clear_slices(); sl[0] = 64'h0000_0000_FFFF_FFFF; sl[15] = 64'd1;
    run_txn("high_hi", 1'b1, 2'b01, 0, 1'b0);
    run_txn("high_lo", 1'b0, 2'b01, 0, 1'b0);
    // Negative wrap
    for (int k = 0; k < SIZE; k++) sl[k] = 64'hFFFF_FFFF_FFFF_FFFF;
    run_txn("neg_lo", 1'b0, 2'b11, 0, 1'b0);
    run_txn("neg_hi", 1'b1, 2'b11, 0, 1'b0);
    // Backpressure, then ignored start during ACC
    random_slices();
    run_txn("bp", 1'b0, 2'b10, 3, 1'b0);
    random_slices();
    run_txn("poke", 1'b1, 2'b01, 1, 1'b1);
    // All-zero request
    clear_slices();
    run_txn("zero", 1'b1, 2'b00, 0, 1'b0);

    // Flush during beat 2
    random_slices(); load_partials();
    higher_i = 1'b0; sign_i = 2'b11; ready_i = 1'b1; start_i = 1'b1;
    @(posedge clk); #1; start_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clear_i = 1'b1;
    @(posedge clk); #1; clear_i = 1'b0;
    check("abort_busy", 64'(busy_o), 64'd0);
    check("abort_valid", 64'(valid_o), 64'd0);
    for (int c = 0; c < NBEAT + 2; c++) begin
      @(posedge clk); #1;
      check("abort_no_valid", 64'(valid_o), 64'd0);
    end
    random_slices();
    run_txn("after_abort", 1'b0, 2'b01, 0, 1'b0);

    // Asynchronous reset mid-ACC, after a known nonzero result
    clear_slices(); sl[0] = 64'd5; sl[1] = 64'd7;
    run_txn("pre_rst", 1'b0, 2'b10, 0, 1'b0);
    random_slices(); load_partials();
    sign_i = 2'b11; start_i = 1'b1;
    @(posedge clk); #1; start_i = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy_o), 64'd0);
    check("arst_valid", 64'(valid_o), 64'd0);
    check("arst_result", 64'(result_o), 64'd0);
    check("arst_sign", 64'(sign_o), 64'd0);
    #1 rst = 1'b0;
    for (int c = 0; c < NBEAT + 2; c++) begin
      @(posedge clk); #1;
      check("arst_no_valid", 64'(valid_o), 64'd0);
    end

    // Randomized requests
    for (int t = 0; t < 20; t++) begin
      random_slices();
      run_txn($sformatf("rand%0d", t), 1'($urandom), 2'($urandom),
              $urandom_range(0, 3), 1'b0);
    end

    p = model_product();
    $display("last product=%h", p);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_accumulate.md
Name: mul_accumulate

Overview:
- Stage directly downstream of the multiplier partial-product pipeline register.
- Consumes SIZE registered 64-bit two's-complement partial products and reduces them iteratively, LANES per cycle, into a 64-bit product.
- Returns the low or high 32-bit half to the writeback side through a valid/ready handshake.

Parameters:
- SIZE, 16, number of 64-bit partial products on partial_i; must be a multiple of LANES.
- LANES, 4, partial products summed per accumulate cycle; SIZE/LANES gives the number of accumulate beats (NBEAT).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start_i  input  1  request strobe from the partial-product register
- partial_i  input  64*SIZE  partial products; slice k is bits [64k+63:64k]
- sign_i  input  2  operand signedness {rs1_signed, rs2_signed}
- higher_i  input  1  1 = return bits [63:32], 0 = return bits [31:0]
- clear_i  input  1  synchronous abort (pipeline flush)
- ready_i  input  1  consumer can accept result
- busy_o  output  1  high in ACC or DONE
- valid_o  output  1  result_o valid
- result_o  output  32  selected product half
- sign_o  output  2  sign_i captured with the request

Behaviour:
- Reset (async, rst=1): state=IDLE; busy_o=0, valid_o=0, result_o=0, sign_o=0; accumulator, beat counter and partial buffer cleared.
- Registers:
  - buf: 64*SIZE partial-product buffer
  - acc: 64-bit accumulator
  - cnt: beat counter, width clog2(NBEAT)+1
  - hi_q: captured higher_i
  - sign_q: captured sign_i
- IDLE:
  - start_i=1 → capture partial_i into buf, higher_i into hi_q, sign_i into sign_q; acc=0, cnt=0; go to ACC.
  - start_i=0 → stay in IDLE.
- ACC, each cycle:
  - acc <= acc + sum of buf slices [cnt*LANES .. cnt*LANES+LANES-1], all 64-bit modulo 2^64 (carry out of bit 63 discarded); cnt++.
  - After the beat with cnt==NBEAT-1, go to DONE.
- DONE:
  - valid_o=1; result_o = hi_q ? acc[63:32] : acc[31:0]; sign_o = sign_q.
  - Result held stable while ready_i=0.
  - valid_o & ready_i → IDLE next cycle; valid_o drops.
- Latency: start_i sampled at edge 0 → valid_o high after edge NBEAT+1 (defaults: 5 cycles).
- sign_i does not affect arithmetic: the upstream generator already sign-extends all partials. sign_i is forwarded only.
- start_i while busy_o=1 (ACC or DONE) is ignored, with no queuing. The upstream stage must hold off while busy_o=1.
- start_i in the same cycle that DONE is accepted: ignored. Start is accepted only in IDLE.
- clear_i=1 in any state → IDLE next edge, valid_o=0, and the result is dropped. clear_i has priority over start_i and the handshake.
- Async rst mid-ACC or mid-DONE: immediate return to the reset values; no partial result is ever emitted.
- result_o stays at its last value outside DONE; consumers qualify it with valid_o.

Optional Feature:
- MUL_ACC_ZERO_SKIP_EN defined:
  - On capture in IDLE, if every partial_i slice is zero, go straight to DONE with acc=0.
  - valid_o is then high one cycle after the start_i edge.
  - A nonzero request keeps the normal NBEAT+1 latency.
- Undefined: no zero-detect logic; every request takes NBEAT+1 cycles.

Test Plan:
- Small sum: defaults; slice0=5, slice1=7, others 0, higher_i=0, ready_i=1 → valid_o after 5 cycles, result_o=0x0000000C, held 1 cycle.
- High half: slice0=0x00000000FFFFFFFF, slice15=1, higher_i=1 → result_o=0x00000001. Same stimulus with higher_i=0 → result_o=0x00000000.
- Negative wrap: all 16 slices=0xFFFFFFFFFFFFFFFF, sign_i=2'b11:
  - higher_i=0 → result_o=0xFFFFFFF0, sign_o=2'b11.
  - higher_i=1 → result_o=0xFFFFFFFF.
- Backpressure and ignored start:
  - ready_i=0 for 3 cycles in DONE → valid_o and result_o stable; idle on the cycle after ready_i rises.
  - A second start_i pulsed during ACC produces no extra result.
- Abort: clear_i during beat 2 → valid_o never asserts, busy_o=0 next cycle, and a new start completes normally. Same check with rst asserted asynchronously mid-ACC → all outputs 0 immediately.
- Zero skip, with MUL_ACC_ZERO_SKIP_EN defined: all slices 0 → valid_o one cycle after start, result_o=0. Without the macro → 5 cycles, result_o=0.
